// File: rtl/load_store_buffer_if.sv
// Bus bundle for load_store_buffer: issue port, CDB snoop, memory dispatch and occupancy.
// perf_stall_cnt exists only when LSB_PERF_EN is defined.
interface load_store_buffer_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          issue_valid;
  logic          issue_ready;
  logic          issue_op;
  logic [3:0]    issue_qj;
  logic [31:0]   issue_vj;
  logic [31:0]   issue_a;
  logic [3:0]    issue_qk;
  logic [31:0]   issue_vk;
  logic [3:0]    issue_label;

  logic          cdb_valid;
  logic [3:0]    cdb_label;
  logic [31:0]   cdb_data;

  logic          mem_ready;
  logic          mem_wen;
  logic          mem_op;
  logic [31:0]   mem_base;
  logic [31:0]   mem_offset;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_label;

  logic [CW-1:0] count;
`ifdef LSB_PERF_EN
  logic [15:0]   perf_stall_cnt;
`endif

  modport master (
    output issue_valid, issue_op, issue_qj, issue_vj, issue_a, issue_qk, issue_vk,
    input  issue_ready, issue_label,
    output cdb_valid, cdb_label, cdb_data,
    output mem_ready,
    input  mem_wen, mem_op, mem_base, mem_offset, mem_wdata, mem_label,
    input  count
`ifdef LSB_PERF_EN
    , input perf_stall_cnt
`endif
  );

  modport slave (
    input  issue_valid, issue_op, issue_qj, issue_vj, issue_a, issue_qk, issue_vk,
    output issue_ready, issue_label,
    input  cdb_valid, cdb_label, cdb_data,
    input  mem_ready,
    output mem_wen, mem_op, mem_base, mem_offset, mem_wdata, mem_label,
    output count
`ifdef LSB_PERF_EN
    , output perf_stall_cnt
`endif
  );
endinterface

// File: rtl/load_store_buffer.sv
// In-order load/store buffer: holds memory ops until operands arrive on the CDB, then
// dispatches the oldest to the memory unit. Macro LSB_PERF_EN adds a head-stall counter.
module load_store_buffer #(
  parameter int         DEPTH      = 4,
  parameter logic [3:0] LABEL_BASE = 4'd8
) (
  input logic                clk,
  input logic                rst_n,
  load_store_buffer_if.slave bus
);
  localparam int            PW         = $clog2(DEPTH);
  localparam int            CW         = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic          r_busy [DEPTH];
  logic          r_op   [DEPTH];
  logic [3:0]    r_qj   [DEPTH];
  logic [31:0]   r_vj   [DEPTH];
  logic [31:0]   r_a    [DEPTH];
  logic [3:0]    r_qk   [DEPTH];
  logic [31:0]   r_vk   [DEPTH];

  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          r_lockout;

  logic          r_mem_wen;
  logic          r_mem_op;
  logic [31:0]   r_mem_base;
  logic [31:0]   r_mem_offset;
  logic [31:0]   r_mem_wdata;
  logic [3:0]    r_mem_label;

  logic          w_issue_fire;
  logic          w_head_ready;
  logic          w_dispatch;
  logic [3:0]    w_issue_qj;
  logic [31:0]   w_issue_vj;
  logic [3:0]    w_issue_qk;
  logic [31:0]   w_issue_vk;

  assign bus.issue_ready = (r_count != FULL_COUNT);
  assign bus.issue_label = LABEL_BASE + 4'(r_tail);
  assign w_issue_fire    = bus.issue_valid && bus.issue_ready;

  // Head eligibility looks only at registered operand state, so a CDB hit counts next cycle.
  assign w_head_ready = r_busy[r_head] && (r_qj[r_head] == 4'd0) &&
                        (r_op[r_head] || (r_qk[r_head] == 4'd0));
  assign w_dispatch   = w_head_ready && bus.mem_ready && !r_lockout;

  // Operands of the op being issued, with same-cycle CDB capture folded in.
  always_comb begin
    w_issue_qj = bus.issue_qj;
    w_issue_vj = bus.issue_vj;
    w_issue_qk = bus.issue_qk;
    w_issue_vk = bus.issue_vk;
    if (bus.cdb_valid && (bus.issue_qj != 4'd0) && (bus.issue_qj == bus.cdb_label)) begin
      w_issue_qj = 4'd0;
      w_issue_vj = bus.cdb_data;
    end else begin
      w_issue_qj = bus.issue_qj;
      w_issue_vj = bus.issue_vj;
    end
    if (bus.issue_op) begin
      w_issue_qk = 4'd0;
      w_issue_vk = bus.issue_vk;
    end else if (bus.cdb_valid && (bus.issue_qk != 4'd0) && (bus.issue_qk == bus.cdb_label)) begin
      w_issue_qk = 4'd0;
      w_issue_vk = bus.cdb_data;
    end else begin
      w_issue_qk = bus.issue_qk;
      w_issue_vk = bus.issue_vk;
    end
  end

  // Entry storage: issue write at tail, busy clear at dispatched head, CDB snoop elsewhere.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_busy[i] <= 1'b0;
        r_op[i]   <= 1'b0;
        r_qj[i]   <= 4'd0;
        r_vj[i]   <= 32'd0;
        r_a[i]    <= 32'd0;
        r_qk[i]   <= 4'd0;
        r_vk[i]   <= 32'd0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_issue_fire && (r_tail == PW'(i))) begin
          r_busy[i] <= 1'b1;
          r_op[i]   <= bus.issue_op;
          r_qj[i]   <= w_issue_qj;
          r_vj[i]   <= w_issue_vj;
          r_a[i]    <= bus.issue_a;
          r_qk[i]   <= w_issue_qk;
          r_vk[i]   <= w_issue_vk;
        end else begin
          if (w_dispatch && (r_head == PW'(i))) begin
            r_busy[i] <= 1'b0;
          end
          if (r_busy[i] && bus.cdb_valid && (r_qj[i] != 4'd0) && (r_qj[i] == bus.cdb_label)) begin
            r_qj[i] <= 4'd0;
            r_vj[i] <= bus.cdb_data;
          end
          if (r_busy[i] && bus.cdb_valid && (r_qk[i] != 4'd0) && (r_qk[i] == bus.cdb_label)) begin
            r_qk[i] <= 4'd0;
            r_vk[i] <= bus.cdb_data;
          end
        end
      end
    end
  end

  // Pointers, occupancy and the one-cycle post-strobe lockout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_lockout <= 1'b0;
    end else begin
      r_lockout <= w_dispatch;
      if (w_issue_fire) begin
        r_tail <= r_tail + PW'(1);
      end
      if (w_dispatch) begin
        r_head <= r_head + PW'(1);
      end
      case ({w_issue_fire, w_dispatch})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Memory request register: data holds between strobes, strobe lasts one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_wen    <= 1'b0;
      r_mem_op     <= 1'b0;
      r_mem_base   <= 32'd0;
      r_mem_offset <= 32'd0;
      r_mem_wdata  <= 32'd0;
      r_mem_label  <= 4'd0;
    end else if (w_dispatch) begin
      r_mem_wen    <= 1'b1;
      r_mem_op     <= r_op[r_head];
      r_mem_base   <= r_vj[r_head];
      r_mem_offset <= r_a[r_head];
      r_mem_wdata  <= r_vk[r_head];
      r_mem_label  <= LABEL_BASE + 4'(r_head);
    end else begin
      r_mem_wen    <= 1'b0;
    end
  end

  assign bus.mem_wen    = r_mem_wen;
  assign bus.mem_op     = r_mem_op;
  assign bus.mem_base   = r_mem_base;
  assign bus.mem_offset = r_mem_offset;
  assign bus.mem_wdata  = r_mem_wdata;
  assign bus.mem_label  = r_mem_label;
  assign bus.count      = r_count;

`ifdef LSB_PERF_EN
  logic [15:0] r_perf_stall_cnt;

  // Saturating count of cycles where the head could go but memory or lockout holds it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_stall_cnt <= 16'd0;
    end else if (w_head_ready && !w_dispatch && (r_perf_stall_cnt != 16'hFFFF)) begin
      r_perf_stall_cnt <= r_perf_stall_cnt + 16'd1;
    end else begin
      r_perf_stall_cnt <= r_perf_stall_cnt;
    end
  end

  assign bus.perf_stall_cnt = r_perf_stall_cnt;
`endif
endmodule
